// File: rtl/burst_mem_pkg.sv
// Shared types and defaults for the burst-capable single-port memory.
// Parity protection is enabled by defining BURST_MEMORY_PARITY_EN.
package burst_mem_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_MAX_BURST = 8;

    typedef enum logic [1:0] {
        IDLE,
        RBURST,
        WBURST
    } state_e;

    // Width of a beat count that must hold the value max_burst itself.
    function automatic int len_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for burst_memory: one read or one write per cycle, registered read.
// With BURST_MEMORY_PARITY_EN defined, an even-parity bit column is kept per word.
module mem_array
    import burst_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              perr_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto RAM macros; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef BURST_MEMORY_PARITY_EN
    logic par_q [DEPTH];
    logic perr_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            par_q[addr_i] <= ^wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= re_i & ((^mem_q[addr_i]) ^ par_q[addr_i]);
        end
    end

    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/burst_memory.sv
// Single-port RAM with 1-cycle single accesses plus wrapping multi-beat bursts.
// Optional per-word parity checking is enabled by defining BURST_MEMORY_PARITY_EN.
module burst_memory
    import burst_mem_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int LEN_W     = len_w(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              parity_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;

    logic [LEN_W-1:0]  beats;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_perr;

    assign beats = (burst_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if ((ren || wen) && beats > LEN_W'(1)) begin
                    state_d = ren ? RBURST : WBURST;
                    ptr_d   = addr + ADDR_W'(1);
                    cnt_d   = beats - LEN_W'(1);
                end
            end
            RBURST, WBURST: begin
                ptr_d = ptr_q + ADDR_W'(1);
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; ren wins over wen.
    always_comb begin
        mem_addr = (state_q == IDLE) ? addr : ptr_q;
        mem_re   = ((state_q == IDLE) && ren) || (state_q == RBURST);
        mem_we   = ((state_q == IDLE) && wen && !ren) || (state_q == WBURST);
        valid_d  = mem_re;
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (din),
        .rdata_o (mem_rdata),
        .perr_o  (mem_perr)
    );

    assign dout       = valid_q ? mem_rdata : '0;
    assign dout_valid = valid_q;
    assign parity_err = valid_q & mem_perr;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: transaction-level model of memory contents,
// burst beat sequence, busy window and ignored requests. Parity test needs BURST_MEMORY_PARITY_EN.
module tb_burst_memory;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 7;
    localparam int MAX_BURST = 8;
    localparam int LEN_W     = 4;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ren = 1'b0;
    logic              wen = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] din = '0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              parity_err;

    always #5 clk = ~clk;

    burst_memory #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ren        (ren),
        .wen        (wen),
        .addr       (addr),
        .din        (din),
        .burst_len  (burst_len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .parity_err (parity_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wbuf [MAX_BURST];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats_of(input bit any_req, input int len);
        if (!any_req || len <= 1) return 1;
        if (len > MAX_BURST) return MAX_BURST;
        return len;
    endfunction

    // Entered on a negedge; returns on the negedge that follows the final beat,
    // i.e. the cycle in which busy has just fallen. noise: 0 none, 1 random, 2 write to addr 5.
    task automatic burst(input bit do_rd, input bit do_wr, input int a, input int len, input int noise);
        int  n;
        bit  is_rd;
        bit  is_wr;
        int  ak;
        is_rd = do_rd;
        is_wr = do_wr && !do_rd;
        n     = beats_of(do_rd || do_wr, len);
        ren       = do_rd;
        wen       = do_wr;
        addr      = ADDR_W'(a);
        burst_len = LEN_W'(len);
        din       = wbuf[0];
        for (int k = 0; k < n; k++) begin
            ak = (a + k) % DEPTH;
            if (is_wr) ref_mem[ak] = wbuf[k];
            @(negedge clk);
            check("dout_valid", 32'(dout_valid), 32'(is_rd));
            check("dout", 32'(dout), is_rd ? 32'(ref_mem[ak]) : 32'(0));
            check("parity_err", 32'(parity_err), 32'(0));
            check("busy", 32'(busy), 32'(k < n - 1));
            ren = 1'b0;
            wen = 1'b0;
            if (k < n - 1) begin
                din = wbuf[k + 1];
                if (noise == 1) begin
                    ren       = 1'($urandom);
                    wen       = 1'($urandom);
                    addr      = ADDR_W'($urandom);
                    burst_len = LEN_W'($urandom);
                end else if (noise == 2) begin
                    wen       = 1'b1;
                    addr      = ADDR_W'(5);
                    burst_len = LEN_W'(1);
                end
            end
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_dout_valid", 32'(dout_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_parity_err", 32'(parity_err), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole memory with back-to-back 8-beat write bursts.
        for (int b = 0; b < DEPTH / MAX_BURST; b++) begin
            for (int k = 0; k < MAX_BURST; k++) wbuf[k] = DATA_W'($urandom);
            burst(1'b0, 1'b1, b * MAX_BURST, MAX_BURST, 0);
        end

        // Single write, read back, then idle.
        wbuf[0] = 8'd87;
        burst(1'b0, 1'b1, 87, 1, 0);
        burst(1'b1, 1'b0, 87, 1, 0);
        burst(1'b0, 1'b0, 0, 0, 0);

        // ren and wen together: read wins, no write happens.
        wbuf[0] = 8'd85;
        burst(1'b1, 1'b1, 15, 1, 0);
        burst(1'b1, 1'b0, 15, 1, 0);

        // Wrapping write burst, then read it back while wen pulses at addr 5 are ignored,
        // followed by a back-to-back burst accepted as busy falls.
        for (int k = 0; k < 4; k++) wbuf[k] = DATA_W'(10 + k);
        burst(1'b0, 1'b1, 126, 4, 0);
        for (int k = 0; k < MAX_BURST; k++) wbuf[k] = 8'hEE;
        burst(1'b1, 1'b0, 126, 4, 2);
        burst(1'b1, 1'b0, 3, 3, 0);
        burst(1'b0, 1'b0, 0, 0, 0);

        // Over-long length clamps to MAX_BURST beats.
        burst(1'b1, 1'b0, 20, 15, 0);

        // Reset three beats into an 8-beat write burst at addr 40.
        for (int k = 0; k < MAX_BURST; k++) wbuf[k] = DATA_W'(8'hA0 + k);
        ren       = 1'b0;
        wen       = 1'b1;
        addr      = ADDR_W'(40);
        burst_len = LEN_W'(8);
        din       = wbuf[0];
        for (int k = 0; k < 3; k++) begin
            ref_mem[40 + k] = wbuf[k];
            @(negedge clk);
            check("abort_busy_pre", 32'(busy), 32'(1));
            wen = 1'b0;
            din = wbuf[k + 1];
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_dout", 32'(dout), 32'(0));
        check("abort_dout_valid", 32'(dout_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        burst(1'b1, 1'b0, 40, 8, 0);

        // Randomised mix of reads, writes, collisions and idles against the model.
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            for (int k = 0; k < MAX_BURST; k++) wbuf[k] = DATA_W'($urandom);
            burst(kind == 0 || kind == 2, kind == 1 || kind == 2,
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, 15), $urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) burst(1'b0, 1'b0, 0, 0, 0);
        end

`ifdef BURST_MEMORY_PARITY_EN
        // Corrupt one stored data bit behind the parity column and read it.
        wbuf[0] = 8'h55;
        burst(1'b0, 1'b1, 9, 1, 0);
        dut.u_mem.mem_q[9][0] = ~dut.u_mem.mem_q[9][0];
        ren       = 1'b1;
        addr      = ADDR_W'(9);
        burst_len = LEN_W'(1);
        @(negedge clk);
        check("par_dout", 32'(dout), 32'(8'h54));
        check("par_valid", 32'(dout_valid), 32'(1));
        check("par_err", 32'(parity_err), 32'(1));
        ren = 1'b0;
        @(negedge clk);
        check("par_err_idle", 32'(parity_err), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised successor to the lab single-port memory.
- Single-port synchronous RAM (DEPTH x DATA_W) with the same ren/wen/addr/din/dout contract for single accesses.
- Adds multi-beat burst reads and writes with address auto-increment, wrap-around and a busy handshake.
- Sits between lab FSM/controller logic and on-chip storage; replaces the fixed 128x8 memory.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 7, address width; DEPTH = 2**ADDR_W (localparam).
- MAX_BURST, 8, maximum beats per burst; LEN_W = $clog2(MAX_BURST+1) (localparam).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- ren  in  1  read request; priority over wen.
- wen  in  1  write request.
- addr  in  ADDR_W  start address of the access.
- din  in  DATA_W  write data, sampled every write beat.
- burst_len  in  LEN_W  beat count; 0 or 1 = single access; values >MAX_BURST clamp to MAX_BURST.
- dout  out  DATA_W  registered read data; 0 when no read beat.
- dout_valid  out  1  high in cycles where dout holds a read beat.
- busy  out  1  high while a burst is in progress; requests ignored.
- parity_err  out  1  read-beat parity mismatch (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; dout=0, dout_valid=0, busy=0, parity_err=0; beat counter and address pointer = 0. Memory contents are not cleared. Reset mid-burst aborts the burst immediately; already-written beats persist.
- States: IDLE, RBURST, WBURST (enum in package).
- IDLE, ren=1 (wen ignored): at the edge, dout<=mem[addr] and dout_valid<=1. Latency is 1 cycle. If N=burst_len>1: go to RBURST, ptr<=addr+1, cnt<=N-1, busy<=1.
- IDLE, wen=1, ren=0: at the edge, mem[addr]<=din, dout<=0, dout_valid<=0. If N>1: go to WBURST, ptr<=addr+1, cnt<=N-1, busy<=1.
- IDLE, neither request: dout<=0, dout_valid<=0.
- RBURST, each edge: dout<=mem[ptr], dout_valid<=1, ptr++, cnt--. On the edge where cnt==1, go to IDLE and set busy<=0.
- WBURST, each edge: mem[ptr]<=din (din sampled this cycle), dout<=0, ptr++, cnt--. On the edge where cnt==1, go to IDLE and set busy<=0.
- busy is high for exactly N-1 cycles. A request presented while busy=1 is ignored (no effect, no queueing).
- A request presented in the cycle busy falls is accepted at the next edge, so back-to-back bursts have no bubble.
- Address arithmetic is modulo DEPTH: ptr wraps from DEPTH-1 to 0.
- addr, ren, wen and burst_len are sampled only at acceptance; later changes during a burst have no effect.

Optional Feature:
- Macro: BURST_MEMORY_PARITY_EN.
- Defined: each word stores an extra even-parity bit (^din) at write time. Every read beat recomputes parity, and parity_err<=1 for that beat on mismatch. parity_err is registered, aligned with dout_valid, and 0 on non-read cycles.
- Undefined: no parity storage; parity_err is tied to 0. Port list is unchanged.

Decomposition:
- Package burst_mem_pkg: state enum (IDLE/RBURST/WBURST), default DATA_W/ADDR_W/MAX_BURST constants, LEN_W helper function.
- Sub-module mem_array: storage only. One read or one write per cycle, registered read, parity bit column under the macro.
- burst_memory holds the FSM, counter, pointer and output registers.

Test Plan:
- Single write then read: wen=1, addr=87, din=87 → next cycle ren=1, addr=87 → dout=87, dout_valid=1 one cycle later; then idle → dout=0.
- ren+wen together: addr=15, din=85, both high → dout=old mem[15]; a following read shows mem[15] unchanged (no write occurred).
- Wrapping write burst: wen, addr=126, burst_len=4, din=10,11,12,13 → busy high 3 cycles; mem[126]=10, mem[127]=11, mem[0]=12, mem[1]=13.
- Read burst with ignored request: ren, addr=126, burst_len=4 → dout 10,11,12,13 on consecutive cycles with dout_valid=1; a wen pulse to addr 5 during busy leaves mem[5] unchanged. A burst requested when busy falls starts with no gap.
- Reset mid-burst: write burst of 8 at addr 40, rst_n low after beat 3 → busy=0, dout=0 immediately; mem[40..42] hold written data, mem[43..47] unchanged.
- Parity (macro defined): write 0x55 at addr 9, backdoor-flip one data bit in mem_array, read addr 9 → parity_err=1 with dout_valid. Without the macro, parity_err stays 0.
